// File: rtl/lcd_pattern_gen.sv
// RGB565 test-pattern source: rebuilds x/y from the timing generator's DE/syncs, pipelines them 1 clk,
// and paints one of four patterns chosen by a debounced key. Optional macro: LCDPAT_AUTO_CYCLE_EN.
module lcd_pattern_gen #(
  parameter int   H_ACTIVE     = 800,
  parameter int   V_ACTIVE     = 480,
  parameter logic SYNC_ACT     = 1'b0,
  parameter int   DEBOUNCE_CYC = 333333,
  parameter int   AUTO_FRAMES  = 120
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       de_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       key_i,
  output logic       de_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b,
  output logic [1:0] pattern_o
);

  localparam logic [10:0]     X_MAX   = 11'(H_ACTIVE - 1);
  localparam logic [9:0]      Y_MAX   = 10'(V_ACTIVE - 1);
  localparam int              BAR_W   = H_ACTIVE / 8;
  localparam int              DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [10:0]     x_reg;
  logic [9:0]      y_reg;
  logic            key_meta_reg;
  logic            key_sync_reg;
  logic            key_db_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            pending_reg;
  logic [1:0]      pattern_reg;

  logic       frame_start;
  logic       de_fall;
  logic       press;
  logic       key_advance;
  logic       advance;
  logic [2:0] bar;
  logic [4:0] pix_r;
  logic [5:0] pix_g;
  logic [4:0] pix_b;

  // de_o/vsync_o hold last cycle's inputs, so they double as edge-detect history
  assign frame_start = (vsync_i == SYNC_ACT) && (vsync_o != SYNC_ACT);
  assign de_fall     = de_o && !de_i;
  assign press       = (key_sync_reg != key_db_reg) && (db_cnt_reg == DB_LAST) && !key_sync_reg;
  assign key_advance = frame_start && (pending_reg || press);
  assign pattern_o   = pattern_reg;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      if (!de_i)
        x_reg <= '0;
      else if (x_reg != X_MAX)
        x_reg <= x_reg + 11'd1;

      if (frame_start)
        y_reg <= '0;
      else if (de_fall && (y_reg != Y_MAX))
        y_reg <= y_reg + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      key_meta_reg <= 1'b1;
      key_sync_reg <= 1'b1;
      key_db_reg   <= 1'b1;
      db_cnt_reg   <= '0;
    end else begin
      key_meta_reg <= key_i;
      key_sync_reg <= key_meta_reg;
      if (key_sync_reg == key_db_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        key_db_reg <= key_sync_reg;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

`ifdef LCDPAT_AUTO_CYCLE_EN
  localparam int              FC_W    = $clog2(AUTO_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt_reg;
  logic            auto_advance;

  assign auto_advance = frame_start && (frame_cnt_reg == FC_LAST);
  assign advance      = key_advance || auto_advance;

  // Any advance, key or auto, restarts the frame count
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)
      frame_cnt_reg <= '0;
    else if (frame_start)
      frame_cnt_reg <= advance ? '0 : frame_cnt_reg + 1'b1;
  end
`else
  logic unused_auto_frames;
  assign unused_auto_frames = ^(32'(AUTO_FRAMES));
  assign advance            = key_advance;
`endif

  // A press landing on the boundary cycle is consumed by that same boundary
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pending_reg <= 1'b0;
      pattern_reg <= 2'd0;
    end else begin
      pending_reg <= frame_start ? 1'b0 : (pending_reg || press);
      if (advance)
        pattern_reg <= pattern_reg + 2'd1;
    end
  end

  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++)
      if (x_reg >= 11'(i * BAR_W))
        bar = 3'(i);
  end

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (pattern_reg)
      2'd0: begin
        // Bar order white..black maps to R=~bar[1], G=~bar[2], B=~bar[0]
        pix_r = {5{~bar[1]}};
        pix_g = {6{~bar[2]}};
        pix_b = {5{~bar[0]}};
      end
      2'd1: begin
        pix_r = x_reg[8:4];
        pix_g = y_reg[8:3];
        pix_b = x_reg[8:4] ^ y_reg[8:4];
      end
      2'd2: begin
        pix_r = {5{x_reg[5] ^ y_reg[5]}};
        pix_g = {6{x_reg[5] ^ y_reg[5]}};
        pix_b = {5{x_reg[5] ^ y_reg[5]}};
      end
      default: begin
        if ((x_reg == 11'd0) || (x_reg == X_MAX) || (y_reg == 10'd0) || (y_reg == Y_MAX) ||
            (x_reg[5:0] == 6'd0) || (y_reg[5:0] == 6'd0)) begin
          pix_r = '1;
          pix_g = '1;
        end
        pix_b = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      de_o    <= 1'b0;
      hsync_o <= ~SYNC_ACT;
      vsync_o <= ~SYNC_ACT;
      lcd_r   <= '0;
      lcd_g   <= '0;
      lcd_b   <= '0;
    end else begin
      de_o    <= de_i;
      hsync_o <= hsync_i;
      vsync_o <= vsync_i;
      lcd_r   <= de_i ? pix_r : 5'd0;
      lcd_g   <= de_i ? pix_g : 6'd0;
      lcd_b   <= de_i ? pix_b : 5'd0;
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen on a reduced 128x64 frame with a short debounce window;
// builds with or without LCDPAT_AUTO_CYCLE_EN.
module tb_lcd_pattern_gen;

  logic       clk = 1'b0;
  logic       nRST;
  logic       de, hs, vs, key;
  logic       de_o, hsync_o, vsync_o;
  logic [4:0] lcd_r;
  logic [5:0] lcd_g;
  logic [4:0] lcd_b;
  logic [1:0] pattern_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] cap [0:255];

  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] BLACK   = 16'h0000;

  lcd_pattern_gen #(
    .H_ACTIVE(128), .V_ACTIVE(64), .SYNC_ACT(1'b0), .DEBOUNCE_CYC(16), .AUTO_FRAMES(2)
  ) dut (
    .clk(clk), .nRST(nRST), .de_i(de), .hsync_i(hs), .vsync_i(vs), .key_i(key),
    .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b), .pattern_o(pattern_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("chk %s obs=%0h exp=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic de_line(input int len);
    de = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      cap[i] = {lcd_r, lcd_g, lcd_b};
    end
    de = 1'b0;
    tick();
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) begin
      de = 1'b1; tick();
      de = 1'b0; tick();
    end
  endtask

  task automatic frame_edge();
    vs = 1'b0; tick();
    vs = 1'b1; tick();
  endtask

  task automatic press(input int low);
    key = 1'b0; tick_n(low);
    key = 1'b1; tick_n(24);
  endtask

  initial begin
    nRST = 1'b0; de = 1'b1; hs = 1'b0; vs = 1'b0; key = 1'b1;
    tick_n(3);
    chk("rst_de", 32'(de_o), 32'd0);
    chk("rst_hs", 32'(hsync_o), 32'd1);
    chk("rst_vs", 32'(vsync_o), 32'd1);
    chk("rst_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'(BLACK));
    chk("rst_pat", 32'(pattern_o), 32'd0);
    de = 1'b0; hs = 1'b1; vs = 1'b1;
    nRST = 1'b1;
    tick_n(3);

    hs = 1'b0; tick();
    chk("hs_pass", 32'(hsync_o), 32'd0);
    chk("vs_idle", 32'(vsync_o), 32'd1);
    hs = 1'b1; vs = 1'b0; tick();
    chk("vs_pass", 32'(vsync_o), 32'd0);
    vs = 1'b1; tick();
    chk("pat_after_vs", 32'(pattern_o), 32'd0);

    de_line(132);
    chk("bar_x0", 32'(cap[0]), 32'(WHITE));
    chk("bar_x15", 32'(cap[15]), 32'(WHITE));
    chk("bar_x16", 32'(cap[16]), 32'(YELLOW));
    chk("bar_x40", 32'(cap[40]), 32'(CYAN));
    chk("bar_x48", 32'(cap[48]), 32'(GREEN));
    chk("bar_x64", 32'(cap[64]), 32'(MAGENTA));
    chk("bar_x80", 32'(cap[80]), 32'(RED));
    chk("bar_x100", 32'(cap[100]), 32'(BLUE));
    chk("bar_x112", 32'(cap[112]), 32'(BLACK));
    chk("bar_x127", 32'(cap[127]), 32'(BLACK));
    chk("blank_de", 32'(de_o), 32'd0);
    chk("blank_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'(BLACK));

`ifdef LCDPAT_AUTO_CYCLE_EN
    frame_edge(); chk("auto_b2", 32'(pattern_o), 32'd1);
    frame_edge(); chk("auto_b3", 32'(pattern_o), 32'd1);
    frame_edge(); chk("auto_b4", 32'(pattern_o), 32'd2);
    press(30);
    frame_edge(); chk("auto_key_b5", 32'(pattern_o), 32'd3);
    frame_edge(); chk("auto_cnt_cleared_b6", 32'(pattern_o), 32'd3);
    press(30);
    frame_edge(); chk("auto_and_key_b7", 32'(pattern_o), 32'd0);
    frame_edge(); chk("auto_b8", 32'(pattern_o), 32'd0);
    frame_edge(); chk("auto_b9", 32'(pattern_o), 32'd1);
`else
    key = 1'b0; tick_n(5);
    key = 1'b1; tick_n(24);
    frame_edge();
    chk("bounce_no_adv", 32'(pattern_o), 32'd0);

    press(30);
    chk("no_adv_midframe", 32'(pattern_o), 32'd0);
    vs = 1'b0; tick();
    chk("adv_at_vsync", 32'(pattern_o), 32'd1);
    vs = 1'b1; tick();

    de_line(40);
    chk("grad_y0_x37", 32'(cap[37]), 32'h1002);
    short_lines(15);
    de_line(40);
    chk("grad_y16_x37", 32'(cap[37]), 32'h1043);

    press(25); press(25); press(25);
    chk("three_hold", 32'(pattern_o), 32'd1);
    frame_edge();
    chk("three_one_adv", 32'(pattern_o), 32'd2);

    de_line(70);
    chk("chk_x31", 32'(cap[31]), 32'(BLACK));
    chk("chk_x32", 32'(cap[32]), 32'(WHITE));
    chk("chk_x64", 32'(cap[64]), 32'(BLACK));

    key = 1'b0; tick_n(16);
    vs = 1'b0; tick();
    chk("edge_before_pending", 32'(pattern_o), 32'd2);
    vs = 1'b1; tick();
    frame_edge();
    chk("edge_after_pending", 32'(pattern_o), 32'd3);

    de_line(132);
    chk("grid_y0_x1", 32'(cap[1]), 32'(WHITE));
    chk("grid_y0_x65", 32'(cap[65]), 32'(WHITE));
    de_line(132);
    chk("grid_y1_x0", 32'(cap[0]), 32'(WHITE));
    chk("grid_y1_x1", 32'(cap[1]), 32'(BLUE));
    chk("grid_y1_x64", 32'(cap[64]), 32'(WHITE));
    chk("grid_y1_x65", 32'(cap[65]), 32'(BLUE));
    chk("grid_y1_x127", 32'(cap[127]), 32'(WHITE));
    chk("grid_x_sat", 32'(cap[130]), 32'(WHITE));
    short_lines(61);
    de_line(4);
    chk("grid_ylast_x1", 32'(cap[1]), 32'(WHITE));
    short_lines(2);
    de_line(4);
    chk("grid_y_sat_x1", 32'(cap[1]), 32'(WHITE));

    key = 1'b1; tick_n(24);
    key = 1'b0; tick_n(17);
    vs = 1'b0; tick();
    chk("same_cycle_wrap", 32'(pattern_o), 32'd0);
    vs = 1'b1; tick();
    frame_edge();
    chk("pending_consumed", 32'(pattern_o), 32'd0);
    key = 1'b1; tick_n(24);

    press(30);
    frame_edge();
    chk("pre_rst_pat", 32'(pattern_o), 32'd1);
    de = 1'b1; tick_n(5);
    chk("pre_rst_de", 32'(de_o), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("midrst_de", 32'(de_o), 32'd0);
    chk("midrst_vs", 32'(vsync_o), 32'd1);
    chk("midrst_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'(BLACK));
    chk("midrst_pat", 32'(pattern_o), 32'd0);
    tick();
    nRST = 1'b1; de = 1'b0;
    tick();
    frame_edge();
    chk("post_rst_pat", 32'(pattern_o), 32'd0);
    de_line(20);
    chk("post_rst_bar_x16", 32'(cap[16]), 32'(YELLOW));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
